xadc_channel_scanner: RTL
=========================

Name: xadc_channel_scanner

Overview:
- DRP master for the XADC: sweeps 13 analog channels (VP/VN plus 12 auxiliary) at a fixed rate and converts each raw conversion code into a 12-bit result with a status flag.
- Results are double-buffered and published atomically once per sweep.
- Sits directly upstream of the bin-to-decimal / seven-segment path and the on-screen voltage text renderer. Both consumers read a frame-consistent result bank.

Parameters:
- N_CH, 13, number of channels scanned (1..16).
- SCAN_PERIOD, 10_000_000, clk cycles between sweep starts (100 ms at 100 MHz).
- DRDY_TIMEOUT, 64, max clk cycles to wait for drp_drdy after a request.
- OVR_LIMIT, 16'hFFD0, raw code above which a channel is flagged over-range.

Ports:
- clk  in  1  system clock (100 MHz domain).
- rst  in  1  asynchronous, active-low reset.
- drp_daddr  out  7  DRP address to XADC.
- drp_den  out  1  DRP enable; one-cycle read strobe.
- drp_do  in  16  DRP read data.
- drp_drdy  in  1  DRP data-ready.
- rd_ch  in  4  result bank read index.
- rd_data  out  12  committed result for rd_ch.
- rd_ovr  out  1  over-range flag for rd_ch.
- rd_err  out  1  timeout flag for rd_ch.
- frame_done  out  1  one-cycle pulse when a new sweep is committed.
- sweep_cnt  out  8  number of committed sweeps, wraps at 255->0.

Behaviour:
- Channel address map:
  - index 0 -> 7'h03 (VP/VN).
  - index k>=1 -> 7'h10 + (k-1); N_CH=13 gives 7'h10..7'h1B.
- FSM states: IDLE, REQ, WAIT, STORE, COMMIT.
  - IDLE: period counter counts up; when it reaches SCAN_PERIOD-1, clear it, set ch=0, go to REQ. The period counter runs in all states, so sweep starts are periodic. If a sweep is still running when the period elapses, the start is latched as pending and taken on entry to IDLE (at most one pending).
  - REQ: drive drp_daddr=map(ch) and drp_den=1 for exactly one cycle, then WAIT. drp_daddr holds its value until the next REQ.
  - WAIT: timeout counter increments each cycle.
    - drp_drdy=1: capture drp_do into the working bank with err=0, then STORE.
    - Counter reaches DRDY_TIMEOUT: working result=0, err=1, ovr=0, then STORE.
    - drdy and timeout in the same cycle: data wins.
  - STORE: if ch==N_CH-1 go to COMMIT, else ch+1 and go to REQ.
  - COMMIT: copy the whole working bank (data, ovr, err) to the committed bank in one cycle; pulse frame_done the same cycle; sweep_cnt+1; go to IDLE.
- Data conversion: result = drp_do[15:4]; ovr = (drp_do > OVR_LIMIT). When ovr=1, result saturates to 12'hFFF.
- drp_drdy outside WAIT is ignored; no state change, no capture.
- drp_den never asserts while a read is outstanding; only one DRP transaction is in flight at a time.
- Read port: rd_data/rd_ovr/rd_err are registered, 1-cycle latency from rd_ch. rd_ch >= N_CH returns 0 with both flags 0.
- Committed bank changes only in COMMIT. A partially completed sweep is never visible to readers.
- Reset (asserted async, released sync to clk):
  - Outputs: drp_den=0, drp_daddr=7'h03, rd_data=0, rd_ovr=0, rd_err=0, frame_done=0, sweep_cnt=0.
  - Internal: both banks cleared, FSM to IDLE, period counter=0, pending start cleared.
  - Reset mid-transaction abandons the read. A late drdy after reset release is ignored because the FSM is in IDLE.

Test Plan:
- Nominal sweep: SCAN_PERIOD=200, XADC model answers drdy 5 cycles after den with drp_do={ch,12'h000}+16'h0100 -> 13 den pulses at addresses 03,10..1B. After frame_done, rd_ch=4 gives rd_data=12'h410 one cycle later, with rd_ovr=0 and rd_err=0.
- Over-range: channel 2 returns 16'hFFE0 -> rd_ch=2 gives rd_data=12'hFFF, rd_ovr=1. Channel 3 returns 16'hFFD0 -> rd_data=12'hFFD, rd_ovr=0.
- Timeout: model withholds drdy for channel 7 -> exactly DRDY_TIMEOUT cycles later the FSM moves on; rd_ch=7 gives rd_data=0, rd_err=1. Remaining channels are correct and frame_done still pulses. A stray drdy arriving in IDLE is ignored.
- Atomic commit: read rd_ch=5 every cycle during the second sweep while the model changes values -> the old value holds until the frame_done cycle, and the new value appears on the following cycle.
- Overrun: drdy latency 20 with SCAN_PERIOD=100 -> the sweep is longer than the period; the next sweep starts immediately after COMMIT. Only one pending start is kept, and sweep_cnt increments by 1 per frame_done.
- Reset mid-WAIT on channel 6 -> all outputs are 0 at once, drp_daddr=7'h03, sweep_cnt=0. The first frame_done after release carries a full fresh sweep.

Source files
------------

// File: rtl/xadc_channel_scanner_if.sv
// rtl/xadc_channel_scanner_if.sv - DRP request/response and result-bank read signals of the XADC channel scanner
interface xadc_channel_scanner_if;
   logic [6:0]  drp_daddr;
   logic        drp_den;
   logic [15:0] drp_do;
   logic        drp_drdy;
   logic [3:0]  rd_ch;
   logic [11:0] rd_data;
   logic        rd_ovr;
   logic        rd_err;
   logic        frame_done;
   logic [7:0]  sweep_cnt;

   // master is the scanner; slave is the XADC plus the result consumers
   modport master (
      output drp_daddr, drp_den, rd_data, rd_ovr, rd_err, frame_done, sweep_cnt,
      input  drp_do, drp_drdy, rd_ch
   );

   modport slave (
      input  drp_daddr, drp_den, rd_data, rd_ovr, rd_err, frame_done, sweep_cnt,
      output drp_do, drp_drdy, rd_ch
   );
endinterface

// File: rtl/xadc_channel_scanner.sv
// rtl/xadc_channel_scanner.sv - periodic DRP sweep of XADC channels into a double-buffered result bank
module xadc_channel_scanner #(
   parameter int unsigned N_CH         = 13,
   parameter int unsigned SCAN_PERIOD  = 10_000_000,
   parameter int unsigned DRDY_TIMEOUT = 64,
   parameter logic [15:0] OVR_LIMIT    = 16'hFFD0
) (
   input  logic                    clk,
   input  logic                    rst,
   xadc_channel_scanner_if.master  bus
);
   localparam int          PW       = $clog2(SCAN_PERIOD + 1);
   localparam int          TW       = $clog2(DRDY_TIMEOUT + 1);
   localparam logic [3:0]  LAST_CH  = 4'(N_CH - 1);
   localparam logic [4:0]  N_CH_W   = 5'(N_CH);
   localparam logic [PW-1:0] PER_LAST = PW'(SCAN_PERIOD - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(DRDY_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_STORE,
      S_COMMIT
   } state_t;

   state_t         state;
   state_t         state_nx;
   logic [3:0]     ch;
   logic [3:0]     ch_nx;
   logic [PW-1:0]  period_cnt;
   logic           period_tick;
   logic           pending;
   logic [TW-1:0]  tmo_cnt;
   logic           cap_data;
   logic           cap_tmo;
   logic           commit;

   logic [11:0]    conv_data;
   logic           conv_ovr;

   logic [11:0]    wk_data [16];
   logic           wk_ovr  [16];
   logic           wk_err  [16];
   logic [11:0]    cm_data [16];
   logic           cm_ovr  [16];
   logic           cm_err  [16];

   logic [6:0]     daddr_q;
   logic           den_q;
   logic           frame_done_q;
   logic [7:0]     sweep_cnt_q;
   logic [11:0]    rd_data_q;
   logic           rd_ovr_q;
   logic           rd_err_q;

   function automatic logic [6:0] ch_addr(input logic [3:0] c);
      return (c == 4'd0) ? 7'h03 : 7'h0F + {3'b000, c};
   endfunction

   assign period_tick = (period_cnt == PER_LAST);
   assign conv_ovr    = (bus.drp_do > OVR_LIMIT);
   assign conv_data   = conv_ovr ? 12'hFFF : bus.drp_do[15:4];

   // Free-running so sweep starts stay on a fixed grid regardless of sweep length
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         period_cnt <= '0;
      end else if (period_tick) begin
         period_cnt <= '0;
      end else begin
         period_cnt <= period_cnt + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending <= 1'b0;
      end else if (state == S_IDLE) begin
         pending <= 1'b0;
      end else if (period_tick) begin
         pending <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      ch_nx    = ch;
      cap_data = 1'b0;
      cap_tmo  = 1'b0;
      commit   = 1'b0;
      case (state)
         S_IDLE: begin
            if (period_tick || pending) begin
               state_nx = S_REQ;
               ch_nx    = 4'd0;
            end
         end
         S_REQ: begin
            state_nx = S_WAIT;
         end
         S_WAIT: begin
            // A response arriving on the timeout cycle is still taken as data
            if (bus.drp_drdy) begin
               cap_data = 1'b1;
               state_nx = S_STORE;
            end else if (tmo_cnt == TMO_LAST) begin
               cap_tmo  = 1'b1;
               state_nx = S_STORE;
            end
         end
         S_STORE: begin
            if (ch == LAST_CH) begin
               state_nx = S_COMMIT;
            end else begin
               ch_nx    = ch + 4'd1;
               state_nx = S_REQ;
            end
         end
         S_COMMIT: begin
            commit   = 1'b1;
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tmo_cnt <= '0;
      end else if (state == S_WAIT) begin
         tmo_cnt <= tmo_cnt + TW'(1);
      end else begin
         tmo_cnt <= '0;
      end
   end

   // den/daddr are registered on entry to REQ so the strobe lines up with the REQ cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ch           <= 4'd0;
         den_q        <= 1'b0;
         daddr_q      <= 7'h03;
         frame_done_q <= 1'b0;
         sweep_cnt_q  <= 8'd0;
      end else begin
         ch           <= ch_nx;
         den_q        <= (state_nx == S_REQ);
         frame_done_q <= commit;
         if (state_nx == S_REQ) begin
            daddr_q <= ch_addr(ch_nx);
         end
         if (commit) begin
            sweep_cnt_q <= sweep_cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 16; i++) begin
            wk_data[i] <= 12'd0;
            wk_ovr[i]  <= 1'b0;
            wk_err[i]  <= 1'b0;
         end
      end else if (cap_data) begin
         wk_data[ch] <= conv_data;
         wk_ovr[ch]  <= conv_ovr;
         wk_err[ch]  <= 1'b0;
      end else if (cap_tmo) begin
         wk_data[ch] <= 12'd0;
         wk_ovr[ch]  <= 1'b0;
         wk_err[ch]  <= 1'b1;
      end
   end

   // Readers only ever see whole sweeps: the committed bank moves in one cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 16; i++) begin
            cm_data[i] <= 12'd0;
            cm_ovr[i]  <= 1'b0;
            cm_err[i]  <= 1'b0;
         end
      end else if (commit) begin
         cm_data <= wk_data;
         cm_ovr  <= wk_ovr;
         cm_err  <= wk_err;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_data_q <= 12'd0;
         rd_ovr_q  <= 1'b0;
         rd_err_q  <= 1'b0;
      end else if ({1'b0, bus.rd_ch} < N_CH_W) begin
         rd_data_q <= cm_data[bus.rd_ch];
         rd_ovr_q  <= cm_ovr[bus.rd_ch];
         rd_err_q  <= cm_err[bus.rd_ch];
      end else begin
         rd_data_q <= 12'd0;
         rd_ovr_q  <= 1'b0;
         rd_err_q  <= 1'b0;
      end
   end

   assign bus.drp_daddr  = daddr_q;
   assign bus.drp_den    = den_q;
   assign bus.frame_done = frame_done_q;
   assign bus.sweep_cnt  = sweep_cnt_q;
   assign bus.rd_data    = rd_data_q;
   assign bus.rd_ovr     = rd_ovr_q;
   assign bus.rd_err     = rd_err_q;
endmodule
